// File: rtl/mor1kx_spr_bus_ctrl_pkg.sv
// rtl/mor1kx_spr_bus_ctrl_pkg.sv - shared SPR group numbers, slave strobes and FSM encodings
// Purpose: constants shared by the SPR bus controller, its interface and benches.
// Ports: none (package).
package mor1kx_spr_bus_ctrl_pkg;

  localparam int SPR_GROUP_WIDTH = 5;
  localparam int SPR_NUM_SLAVES  = 4;

  // SPR group numbers (addr[15:11])
  localparam logic [SPR_GROUP_WIDTH-1:0] SPR_GROUP_DMMU   = 5'd1;
  localparam logic [SPR_GROUP_WIDTH-1:0] SPR_GROUP_IMMU   = 5'd2;
  localparam logic [SPR_GROUP_WIDTH-1:0] SPR_GROUP_DCACHE = 5'd3;
  localparam logic [SPR_GROUP_WIDTH-1:0] SPR_GROUP_ICACHE = 5'd4;

  // Slave index k owns stb/ack bit k and read-data slice k
  localparam int SPR_SLV_DMMU   = 0;
  localparam int SPR_SLV_IMMU   = 1;
  localparam int SPR_SLV_DCACHE = 2;
  localparam int SPR_SLV_ICACHE = 3;

  // One-hot strobe for each slave
  localparam logic [SPR_NUM_SLAVES-1:0] SPR_STB_DMMU   = 4'b0001;
  localparam logic [SPR_NUM_SLAVES-1:0] SPR_STB_IMMU   = 4'b0010;
  localparam logic [SPR_NUM_SLAVES-1:0] SPR_STB_DCACHE = 4'b0100;
  localparam logic [SPR_NUM_SLAVES-1:0] SPR_STB_ICACHE = 4'b1000;

  // Sequencer state encodings
  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_ACCESS_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_ACCESS = ST_ACCESS_ENC,
    ST_DONE   = ST_DONE_ENC
  } spr_state_t;

endpackage

// File: rtl/mor1kx_spr_bus_ctrl_if.sv
// rtl/mor1kx_spr_bus_ctrl_if.sv - slave-side SPR bus bundle
// Purpose: groups the strobed SPR bus between the sequencer (master) and the slaves.
// Ports (signals):
//   spr_bus_addr_o  16    registered SPR address
//   spr_bus_we_o    1     registered write enable
//   spr_bus_stb_o   4     one-hot strobe {ICACHE,DCACHE,IMMU,DMMU}
//   spr_bus_dat_o   OW    registered write data
//   spr_bus_ack_i   4     per-slave ack, same bit order as stb
//   spr_bus_dat_i   4*OW  per-slave read data, slice k from slave k
interface mor1kx_spr_bus_ctrl_if
  import mor1kx_spr_bus_ctrl_pkg::*;
#(
  parameter int OW = 32
);

  logic [15:0]               spr_bus_addr_o;
  logic                      spr_bus_we_o;
  logic [SPR_NUM_SLAVES-1:0] spr_bus_stb_o;
  logic [OW-1:0]             spr_bus_dat_o;
  logic [SPR_NUM_SLAVES-1:0] spr_bus_ack_i;
  logic [4*OW-1:0]           spr_bus_dat_i;

  modport master (
    output spr_bus_addr_o,
    output spr_bus_we_o,
    output spr_bus_stb_o,
    output spr_bus_dat_o,
    input  spr_bus_ack_i,
    input  spr_bus_dat_i
  );

  modport slave (
    input  spr_bus_addr_o,
    input  spr_bus_we_o,
    input  spr_bus_stb_o,
    input  spr_bus_dat_o,
    output spr_bus_ack_i,
    output spr_bus_dat_i
  );

endinterface

// File: rtl/mor1kx_spr_bus_ctrl.sv
// rtl/mor1kx_spr_bus_ctrl.sv - SPR bus sequencer between mtspr/mfspr and the SPR slaves
// Purpose: decodes the SPR group, runs one strobed access, returns data/ack or a timeout error.
// Ports:
//   clk, rst (sync, active-high)
//   spr_req_i / spr_req_we_i / spr_req_addr_i / spr_req_dat_i  request from control stage
//   flush_i                       suppresses completion of the in-flight access
//   busy_o / spr_done_o / spr_dat_o / spr_err_o  status and completion
//   bus                           slave-side SPR bus (master modport)
module mor1kx_spr_bus_ctrl
  import mor1kx_spr_bus_ctrl_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TIMEOUT_CYCLES       = 16
)(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            spr_req_i,
  input  logic                            spr_req_we_i,
  input  logic [15:0]                     spr_req_addr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_req_dat_i,
  input  logic                            flush_i,
  output logic                            busy_o,
  output logic                            spr_done_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_dat_o,
  output logic                            spr_err_o,
  mor1kx_spr_bus_ctrl_if.master           bus
);

  localparam int         OW      = OPTION_OPERAND_WIDTH;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  function automatic logic [SPR_NUM_SLAVES-1:0] group_stb(input logic [15:0] addr);
    case (addr[15:11])
      SPR_GROUP_DMMU:   group_stb = SPR_STB_DMMU;
      SPR_GROUP_IMMU:   group_stb = SPR_STB_IMMU;
      SPR_GROUP_DCACHE: group_stb = SPR_STB_DCACHE;
      SPR_GROUP_ICACHE: group_stb = SPR_STB_ICACHE;
      default:          group_stb = '0;
    endcase
  endfunction

  spr_state_t                state_q, state_nxt;
  logic [15:0]               addr_q;
  logic                      we_q;
  logic [OW-1:0]             wdat_q;
  logic [SPR_NUM_SLAVES-1:0] stb_q;
  logic [7:0]                cnt_q;
  logic [OW-1:0]             rdat_q;
  logic                      err_q;
  logic                      flush_q;

  logic                      accept;
  logic [SPR_NUM_SLAVES-1:0] req_stb;
  logic                      sel_ack;
  logic                      expire;
  logic [OW-1:0]             sel_dat;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    req_stb   = group_stb(spr_req_addr_i);
    // Acks from slaves that are not strobed are ignored
    sel_ack   = |(bus.spr_bus_ack_i & stb_q);
    expire    = (cnt_q == TO_LAST);
    sel_dat   = '0;
    for (int k = 0; k < SPR_NUM_SLAVES; k++) begin
      if (stb_q[k]) sel_dat = bus.spr_bus_dat_i[k*OW +: OW];
    end
    case (state_q)
      ST_IDLE: begin
        // A request coinciding with a flush belongs to a squashed instruction
        if (spr_req_i && !flush_i) begin
          accept    = 1'b1;
          state_nxt = (|req_stb) ? ST_ACCESS : ST_DONE;
        end
      end
      ST_ACCESS: if (sel_ack || expire) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      stb_q   <= '0;
      cnt_q   <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          flush_q <= 1'b0;
          if (accept) begin
            addr_q <= spr_req_addr_i;
            we_q   <= spr_req_we_i;
            wdat_q <= spr_req_dat_i;
            stb_q  <= req_stb;
            cnt_q  <= '0;
            rdat_q <= '0;
            err_q  <= 1'b0;
          end
        end
        ST_ACCESS: begin
          // Flush never withdraws stb; it only hides the completion
          if (flush_i) flush_q <= 1'b1;
          cnt_q <= cnt_q + 8'd1;
          if (sel_ack) begin
            stb_q  <= '0;
            rdat_q <= we_q ? '0 : sel_dat;
            err_q  <= 1'b0;
          end else if (expire) begin
            stb_q  <= '0;
            rdat_q <= '0;
            err_q  <= 1'b1;
          end
        end
        ST_DONE: if (flush_i) flush_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  // flush_i is also gated directly so a flush arriving in the DONE cycle itself is honoured
  assign spr_done_o = (state_q == ST_DONE) && !flush_q && !flush_i;
  assign spr_dat_o  = rdat_q;
  assign spr_err_o  = spr_done_o && err_q;

  assign bus.spr_bus_addr_o = addr_q;
  assign bus.spr_bus_we_o   = we_q;
  assign bus.spr_bus_stb_o  = stb_q;
  assign bus.spr_bus_dat_o  = wdat_q;

endmodule

// File: tb/tb_mor1kx_spr_bus_ctrl.sv
// tb/tb_mor1kx_spr_bus_ctrl.sv - self-checking bench for the SPR bus sequencer
module tb_mor1kx_spr_bus_ctrl;

  localparam int OW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          spr_req_i = 1'b0;
  logic          spr_req_we_i = 1'b0;
  logic [15:0]   spr_req_addr_i = '0;
  logic [OW-1:0] spr_req_dat_i = '0;
  logic          flush_i = 1'b0;
  logic          busy_o;
  logic          spr_done_o;
  logic [OW-1:0] spr_dat_o;
  logic          spr_err_o;

  always #5 clk = ~clk;

  mor1kx_spr_bus_ctrl_if #(.OW(OW)) bus ();

  mor1kx_spr_bus_ctrl #(
    .OPTION_OPERAND_WIDTH(OW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spr_req_i(spr_req_i),
    .spr_req_we_i(spr_req_we_i),
    .spr_req_addr_i(spr_req_addr_i),
    .spr_req_dat_i(spr_req_dat_i),
    .flush_i(flush_i),
    .busy_o(busy_o),
    .spr_done_o(spr_done_o),
    .spr_dat_o(spr_dat_o),
    .spr_err_o(spr_err_o),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_e;
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   req_cyc = 0;
  int   done_cyc = 0;
  int   done_cnt = 0;
  int   stb_hi = 0;
  int   d0 = 0;
  logic [3:0] stb_last = '0;
  logic [3:0] prev1 = '0;
  logic [3:0] prev2 = '0;
  logic       mon_en = 1'b0;

  // Slave model: slave k acks in stb cycle delay[k]+1 unless silent; spur forces acks
  int   delay [4];
  int   scnt [4];
  logic [3:0] silent = '0;
  logic [3:0] spur = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 4; k++)
      scnt[k] <= bus.spr_bus_stb_o[k] ? scnt[k] + 1 : 0;
  end

  always_comb begin
    bus.spr_bus_ack_i = '0;
    for (int k = 0; k < 4; k++)
      bus.spr_bus_ack_i[k] = (bus.spr_bus_stb_o[k] && !silent[k] && scnt[k] == delay[k]) || spur[k];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on completion plus bus invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (spr_done_o === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("sb_dat", spr_dat_o, exp_e.dat);
          check("sb_err", {31'd0, spr_err_o}, {31'd0, exp_e.err});
        end
      end
      check("stb_onehot", {31'd0, ($countones(bus.spr_bus_stb_o) <= 1)}, 32'd1);
      check("stb_gap", {31'd0, (bus.spr_bus_stb_o != 0 && prev1 == 0 && prev2 != 0)}, 32'd0);
      if (bus.spr_bus_stb_o != 0) begin
        stb_hi++;
        stb_last = bus.spr_bus_stb_o;
      end
      prev2 = prev1;
      prev1 = bus.spr_bus_stb_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [15:0] a, input logic [31:0] d);
    stb_hi         = 0;
    spr_req_i      = 1'b1;
    spr_req_we_i   = we;
    spr_req_addr_i = a;
    spr_req_dat_i  = d;
    req_cyc        = cyc;
    step();
    spr_req_i      = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      if (!busy_o) break;
      step();
    end
    check("idle_reached", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_done"}, {31'd0, spr_done_o}, 32'd0);
    check({tag, "_err"}, {31'd0, spr_err_o}, 32'd0);
    check({tag, "_dat"}, spr_dat_o, 32'd0);
    check({tag, "_stb"}, {28'd0, bus.spr_bus_stb_o}, 32'd0);
    check({tag, "_addr"}, {16'd0, bus.spr_bus_addr_o}, 32'd0);
    check({tag, "_we"}, {31'd0, bus.spr_bus_we_o}, 32'd0);
    check({tag, "_bdat"}, bus.spr_bus_dat_o, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) delay[k] = 0;
    bus.spr_bus_dat_i = {32'h1CAC4E33, 32'hC0FFEE22, 32'hDEADBEEF, 32'h11110000};

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // mfspr IMMU, ack in third stb cycle
    delay[1] = 2;
    d0 = done_cnt;
    exp_q.push_back('{dat: 32'hDEADBEEF, err: 1'b0});
    issue(1'b0, 16'h1005, 32'h0);
    wait_idle();
    check("immu_stb_cycles", stb_hi, 32'd3);
    check("immu_stb_sel", {28'd0, stb_last}, 32'h2);
    check("immu_done_cnt", done_cnt - d0, 32'd1);
    check("immu_addr", {16'd0, bus.spr_bus_addr_o}, 32'h1005);
    check("immu_latency", done_cyc - req_cyc, 32'd4);

    // mtspr DMMU, combinational ack; back-to-back unmapped request
    delay[0] = 0;
    exp_q.push_back('{dat: 32'h0, err: 1'b0});
    issue(1'b1, 16'h0812, 32'h12345678);
    check("dmmu_stb", {28'd0, bus.spr_bus_stb_o}, 32'h1);
    check("dmmu_bdat", bus.spr_bus_dat_o, 32'h12345678);
    check("dmmu_we", {31'd0, bus.spr_bus_we_o}, 32'd1);
    wait_idle();
    check("dmmu_latency", done_cyc - req_cyc, 32'd2);
    check("dmmu_next_accept", cyc - req_cyc, 32'd3);
    check("dmmu_stb_cycles", stb_hi, 32'd1);

    exp_q.push_back('{dat: 32'h0, err: 1'b0});
    issue(1'b0, 16'h4800, 32'h0);
    wait_idle();
    check("unmapped_latency", done_cyc - req_cyc, 32'd1);
    check("unmapped_no_stb", stb_hi, 32'd0);

    // mfspr DCACHE with one wait cycle
    delay[2] = 1;
    exp_q.push_back('{dat: 32'hC0FFEE22, err: 1'b0});
    issue(1'b0, 16'h1803, 32'h0);
    wait_idle();
    check("dcache_stb_cycles", stb_hi, 32'd2);

    // DCACHE silent: timeout
    silent[2] = 1'b1;
    exp_q.push_back('{dat: 32'h0, err: 1'b1});
    issue(1'b0, 16'h1801, 32'h0);
    wait_idle();
    check("timeout_stb_cycles", stb_hi, TO);
    check("timeout_latency", done_cyc - req_cyc, TO + 1);
    check("timeout_stb_sel", {28'd0, stb_last}, 32'h4);
    silent[2] = 1'b0;

    // ICACHE with spurious DMMU ack and flush in ACCESS cycle 2
    delay[3] = 3;
    spur = 4'b0001;
    d0 = done_cnt;
    issue(1'b0, 16'h2000, 32'h0);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    wait_idle();
    spur = 4'b0000;
    check("flush_no_done", done_cnt - d0, 32'd0);
    check("flush_stb_cycles", stb_hi, 32'd4);
    check("flush_stb_sel", {28'd0, stb_last}, 32'h8);
    check("flush_busy_low", {31'd0, busy_o}, 32'd0);

    // Reset in second ACCESS cycle, then a normal request
    silent[2] = 1'b1;
    d0 = done_cnt;
    issue(1'b0, 16'h1800, 32'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midrst");
    step();
    silent[2] = 1'b0;
    delay[2] = 0;
    exp_q.push_back('{dat: 32'hC0FFEE22, err: 1'b0});
    issue(1'b0, 16'h1800, 32'h0);
    wait_idle();
    check("post_rst_done_cnt", done_cnt - d0, 32'd1);
    check("post_rst_stb_cycles", stb_hi, 32'd1);

    step();
    check("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
